alu_exec_unit: RTL and testbench

//  Execute-stage ALU consuming the 4-bit Operation code produced by the ALU control decoder.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 31 +++
 rtl/alu_exec_unit.sv | 168 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the ALU execute unit.
// Defining ALU_MUL_EN adds the iterative MUL state.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1111;
  localparam logic [3:0] OP_MUL = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef ALU_MUL_EN
    MUL   = 2'd3,
`endif
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU ops plus illegal-opcode detection.
// SLL (and MUL when ALU_MUL_EN is defined) are legal here but produced by the iterative top.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             illegal
);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLL:  res = '0;
`ifdef ALU_MUL_EN
      OP_MUL:  res = '0;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops, 1-bit/cycle SLL, valid/ready on both sides.
// Defining ALU_MUL_EN enables a shift-add MUL on opcode 0011 (otherwise it reports illegal).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int LOG_W = $clog2(WIDTH) + 1;
  localparam int CNT_W = (SHAMT_W + 1 > LOG_W) ? SHAMT_W + 1 : LOG_W;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;
  logic [WIDTH-1:0]   core_res;
  logic               core_ill;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               ld;
  logic               ld_ill;
  logic [WIDTH-1:0]   ld_val;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mul_sum;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op      (Operation),
    .a       (a),
    .b       (b),
    .res     (core_res),
    .illegal (core_ill)
  );

  assign shamt    = b[SHAMT_W-1:0];
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
`ifdef ALU_MUL_EN
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q && !out_ready;
    ld          = 1'b0;
    ld_val      = '0;
    ld_ill      = 1'b0;
`ifdef ALU_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (Operation == OP_SLL && shamt != '0) begin
            acc_d   = a;
            cnt_d   = CNT_W'(shamt);
            state_d = SHIFT;
          end else if (Operation == OP_SLL) begin
            ld     = 1'b1;
            ld_val = a;
`ifdef ALU_MUL_EN
          end else if (Operation == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = MUL;
`endif
          end else begin
            ld     = 1'b1;
            ld_val = core_res;
            ld_ill = core_ill;
          end
        end
      end
      // The final iteration writes the result directly so latency is shamt+1.
      SHIFT: begin
        acc_d = acc_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          ld      = 1'b1;
          ld_val  = acc_q << 1;
          state_d = DONE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          ld      = 1'b1;
          ld_val  = mul_sum;
          state_d = DONE;
        end
      end
`endif
      // Hold here until the iterative result is taken downstream.
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ld) begin
      result_d    = ld_val;
      zero_d      = (ld_val == '0);
      illegal_d   = ld_ill;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
`ifdef ALU_MUL_EN
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
`endif
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases, randomized ops against a
// behavioural model, backpressure/back-to-back scoreboard, and reset abort.
module tb_alu_exec_unit;

  localparam int WIDTH = 64;
  localparam logic [3:0] T_AND = 4'b0000;
  localparam logic [3:0] T_OR  = 4'b0001;
  localparam logic [3:0] T_ADD = 4'b0010;
  localparam logic [3:0] T_SUB = 4'b0110;
  localparam logic [3:0] T_SLL = 4'b1111;
  localparam logic [3:0] T_MUL = 4'b0011;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(6)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  // Reference behaviour: result value, illegal flag and latency in cycles.
  function automatic void model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic il, output int lat);
    r = '0; il = 1'b0; lat = 1;
    case (o)
      T_AND: r = x & y;
      T_OR:  r = x | y;
      T_ADD: r = x + y;
      T_SUB: r = x - y;
      T_SLL: begin
        r   = x << y[5:0];
        lat = (y[5:0] == 6'd0) ? 1 : int'(y[5:0]) + 1;
      end
`ifdef ALU_MUL_EN
      T_MUL: begin
        r   = x * y;
        lat = WIDTH + 1;
      end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] pick_op(input int sel);
    logic [3:0] o;
    case (sel)
      0: o = T_AND;
      1: o = T_OR;
      2: o = T_ADD;
      3: o = T_SUB;
      4: o = T_SLL;
      5: o = T_MUL;
      default: o = 4'($urandom);
    endcase
    return o;
  endfunction

  // Issue one op with out_ready=1, then wait (bounded) for its result.
  task automatic send(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                      output logic [63:0] r, output logic z, output logic il,
                      output int lat, output bit rdy_seen, output bit got);
    int guard;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    got = out_valid;
    r = result; z = zero; il = illegal;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (result !== 64'd0) $display("FAIL reset_result: got %h want 0", result); else n_pass++;
    n_total++; if (zero !== 1'b0) $display("FAIL reset_zero: got %b want 0", zero); else n_pass++;
    n_total++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    // Abort an SLL a=1,b=40 partway through.
    op = T_SLL; a = 64'd1; b = 64'd40; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_total++; if (in_ready !== 1'b0) $display("FAIL midsll_busy: in_ready got %b want 0", in_ready); else n_pass++;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midsll_reset_out_valid: got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL midsll_in_ready: got %b want 1", in_ready); else n_pass++;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL midsll_no_result: out_valid seen %b want 0", seen); else n_pass++;
  endtask

  task automatic test_directed();
    logic [3:0]  d_op  [11];
    logic [63:0] d_a   [11];
    logic [63:0] d_b   [11];
    logic [63:0] d_r   [11];
    logic        d_il  [11];
    int          d_lat [11];
    logic [63:0] r;
    logic z, il;
    int lat;
    bit rdy_seen, got;
    d_op[0] = T_ADD; d_a[0] = 64'd5;    d_b[0] = 64'd7;    d_r[0] = 64'd12;   d_il[0] = 0; d_lat[0] = 1;
    d_op[1] = T_SUB; d_a[1] = 64'd9;    d_b[1] = 64'd9;    d_r[1] = 64'd0;    d_il[1] = 0; d_lat[1] = 1;
    d_op[2] = T_AND; d_a[2] = 64'hF0;   d_b[2] = 64'h3C;   d_r[2] = 64'h30;   d_il[2] = 0; d_lat[2] = 1;
    d_op[3] = T_OR;  d_a[3] = 64'hF0;   d_b[3] = 64'h3C;   d_r[3] = 64'hFC;   d_il[3] = 0; d_lat[3] = 1;
    d_op[4] = T_ADD; d_a[4] = '1;       d_b[4] = 64'd1;    d_r[4] = 64'd0;    d_il[4] = 0; d_lat[4] = 1;
    d_op[5] = T_SLL; d_a[5] = 64'd1;    d_b[5] = 64'd3;    d_r[5] = 64'd8;    d_il[5] = 0; d_lat[5] = 4;
    d_op[6] = T_SLL; d_a[6] = 64'd1;    d_b[6] = 64'd0;    d_r[6] = 64'd1;    d_il[6] = 0; d_lat[6] = 1;
`ifdef ALU_MUL_EN
    d_op[7] = T_MUL; d_a[7] = 64'd6;    d_b[7] = 64'd7;    d_r[7] = 64'd42;   d_il[7] = 0; d_lat[7] = 65;
`else
    d_op[7] = T_MUL; d_a[7] = 64'd6;    d_b[7] = 64'd7;    d_r[7] = 64'd0;    d_il[7] = 1; d_lat[7] = 1;
`endif
    d_op[8] = T_SLL; d_a[8] = 64'd1;    d_b[8] = 64'd63;   d_r[8] = 64'h8000_0000_0000_0000; d_il[8] = 0; d_lat[8] = 64;
    d_op[9] = 4'b1010; d_a[9] = 64'd3;  d_b[9] = 64'd4;    d_r[9] = 64'd0;    d_il[9] = 1; d_lat[9] = 1;
    d_op[10] = T_SLL; d_a[10] = 64'd3;  d_b[10] = 64'd66;  d_r[10] = 64'd12;  d_il[10] = 0; d_lat[10] = 3;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(d_op[i], d_a[i], d_b[i], r, z, il, lat, rdy_seen, got);
      n_total++; if (got !== 1'b1) $display("FAIL dir%0d_timeout: out_valid got %b want 1", i, got); else n_pass++;
      n_total++; if (r !== d_r[i]) $display("FAIL dir%0d_result: got %h want %h", i, r, d_r[i]); else n_pass++;
      n_total++; if (z !== (d_r[i] == 64'd0)) $display("FAIL dir%0d_zero: got %b want %b", i, z, d_r[i] == 64'd0); else n_pass++;
      n_total++; if (il !== d_il[i]) $display("FAIL dir%0d_illegal: got %b want %b", i, il, d_il[i]); else n_pass++;
      n_total++; if (lat != d_lat[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, d_lat[i]); else n_pass++;
      if (d_lat[i] > 1) begin
        n_total++; if (rdy_seen !== 1'b0) $display("FAIL dir%0d_busy: in_ready seen %b want 0", i, rdy_seen); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [63:0] x, y, er, r;
    logic eil, z, il;
    int elat, lat;
    bit rdy_seen, got;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      o = pick_op(int'($urandom_range(0, 6)));
      x = {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? x : {$urandom, $urandom};
      model(o, x, y, er, eil, elat);
      send(o, x, y, r, z, il, lat, rdy_seen, got);
      n_total++; if (got !== 1'b1) $display("FAIL rnd%0d_timeout: op %b out_valid got %b want 1", i, o, got); else n_pass++;
      n_total++; if (r !== er) $display("FAIL rnd%0d_result: op %b got %h want %h", i, o, r, er); else n_pass++;
      n_total++; if (z !== (er == 64'd0)) $display("FAIL rnd%0d_zero: got %b want %b", i, z, er == 64'd0); else n_pass++;
      n_total++; if (il !== eil) $display("FAIL rnd%0d_illegal: op %b got %b want %b", i, o, il, eil); else n_pass++;
      n_total++; if (lat != elat) $display("FAIL rnd%0d_latency: op %b got %0d want %0d", i, o, lat, elat); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 30;
    logic [63:0] q_r[$];
    logic        q_il[$];
    logic [63:0] er, h_r, x, y;
    logic eil, h_z, h_il, stalled, took;
    logic [3:0] o;
    int elat, cyc, sent, recv, sel;
    cyc = 0; sent = 0; recv = 0; stalled = 1'b0; took = 1'b0;
    h_r = '0; h_z = 1'b0; h_il = 1'b0;
    in_valid = 1'b0;
    while (recv < N && cyc < 3000) begin
      @(negedge clk);
      if (stalled) begin
        n_total++;
        if ({out_valid, result, zero, illegal} !== {1'b1, h_r, h_z, h_il})
          $display("FAIL b2b_hold: got v=%b r=%h z=%b i=%b want v=1 r=%h z=%b i=%b",
                   out_valid, result, zero, illegal, h_r, h_z, h_il);
        else n_pass++;
      end
      out_ready = (cyc >= 2 && cyc <= 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (took) in_valid = 1'b0;
      if (!in_valid && sent < N) begin
        sel = int'($urandom_range(0, 5));
        o = (sel == 5) ? 4'b0111 : pick_op(sel);
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        if (o == T_SLL) y = {y[63:6], 6'(int'($urandom_range(0, 5)))};
        op = o; a = x; b = y; in_valid = 1'b1;
      end
      #1;
      if (out_valid && !out_ready) begin
        n_total++; if (in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready: got %b want 0", in_ready); else n_pass++;
      end
      stalled = out_valid && !out_ready;
      h_r = result; h_z = zero; h_il = illegal;
      if (out_valid && out_ready) begin
        n_total++;
        if (q_r.size() == 0) begin
          $display("FAIL b2b_extra_result: got %h want none", result);
        end else begin
          n_pass++;
          er = q_r.pop_front();
          eil = q_il.pop_front();
          n_total++; if (result !== er) $display("FAIL b2b_result%0d: got %h want %h", recv, result, er); else n_pass++;
          n_total++; if (zero !== (er == 64'd0)) $display("FAIL b2b_zero%0d: got %b want %b", recv, zero, er == 64'd0); else n_pass++;
          n_total++; if (illegal !== eil) $display("FAIL b2b_illegal%0d: got %b want %b", recv, illegal, eil); else n_pass++;
        end
        recv++;
      end
      took = in_valid && in_ready;
      if (took) begin
        model(op, a, b, er, eil, elat);
        q_r.push_back(er);
        q_il.push_back(eil);
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_total++; if (recv != N) $display("FAIL b2b_count: received %0d want %0d", recv, N); else n_pass++;
    n_total++; if (q_r.size() != 0) $display("FAIL b2b_lost: %0d pending want 0", q_r.size()); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: out_valid got %b want 0", out_valid); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
